// File: rtl/sys_timer_multi.sv
// sys_timer_multi: CHANNELS independent interval timers behind a 16-bit Avalon-MM slave.
// Each channel is a down-counter with a programmable period, one-shot/continuous mode, snapshot and timeout flag.
module sys_timer_multi #(
  parameter int          CHANNELS     = 2,
  parameter int          COUNT_W      = 32,
  parameter logic [31:0] RESET_PERIOD = 32'h0000C34F,
  parameter int          PRESCALE     = 1,
  localparam int         ADDR_W       = 3 + ((CHANNELS > 1) ? $clog2(CHANNELS) : 0)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [15:0]       writedata,
  output logic [15:0]       readdata,
  output logic              irq
);

  localparam int                 PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [COUNT_W-1:0] RST_CNT = COUNT_W'(RESET_PERIOD);

  logic [PS_W-1:0] presc_q;
  logic            tick;
  logic            wr;
  logic [2:0]      offset;
  logic [7:0]      ch_sel;

  logic [CHANNELS-1:0] to_v;
  logic [CHANNELS-1:0] run_v;
  logic [CHANNELS-1:0] ito_v;
  logic [CHANNELS-1:0] cont_v;
  logic [31:0]         period_v [CHANNELS];
  logic [31:0]         snap_v   [CHANNELS];
  logic [15:0]         rd_p0;

  assign tick = (presc_q == PS_W'(PRESCALE - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q <= '0;
    end else if (tick) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + 1'b1;
    end
  end

  assign wr     = chipselect && !write_n;
  assign offset = address[2:0];

  // With a single channel there are no channel-select address bits.
  if (ADDR_W > 3) begin : g_chsel
    assign ch_sel = 8'(address[ADDR_W-1:3]);
  end else begin : g_nochsel
    assign ch_sel = '0;
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic               to_q;
    logic               run_q;
    logic               ito_q;
    logic               cont_q;
    logic               force_reload_p1;
    logic [COUNT_W-1:0] cnt_q;
    logic [COUNT_W-1:0] period_q;
    logic [COUNT_W-1:0] snap_q;
    logic               sel;
    logic               wr_status;
    logic               wr_ctrl;
    logic               wr_pl;
    logic               wr_ph;
    logic               wr_snap;
    logic               timeout;
    logic [31:0]        period_wide;

    assign sel         = wr && (ch_sel == 8'(c));
    assign wr_status   = sel && (offset == 3'd0);
    assign wr_ctrl     = sel && (offset == 3'd1);
    assign wr_pl       = sel && (offset == 3'd2);
    assign wr_ph       = sel && (offset == 3'd3) && (COUNT_W > 16);
    assign wr_snap     = sel && ((offset == 3'd4) || (offset == 3'd5));
    assign period_wide = 32'(period_q);
    // A pending reload pre-empts the zero-count tick, so no timeout is raised then.
    assign timeout     = run_q && tick && (cnt_q == '0) && !force_reload_p1;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        to_q            <= 1'b0;
        run_q           <= 1'b0;
        ito_q           <= 1'b0;
        cont_q          <= 1'b0;
        force_reload_p1 <= 1'b0;
        cnt_q           <= RST_CNT;
        period_q        <= RST_CNT;
        snap_q          <= '0;
      end else begin
        force_reload_p1 <= wr_pl || wr_ph;

        if (wr_pl) begin
          period_q <= COUNT_W'({period_wide[31:16], writedata});
        end else if (wr_ph) begin
          period_q <= COUNT_W'({writedata, period_wide[15:0]});
        end

        if (wr_ctrl) begin
          ito_q  <= writedata[0];
          cont_q <= writedata[1];
        end

        if (wr_snap) begin
          snap_q <= cnt_q;
        end

        if (force_reload_p1) begin
          cnt_q <= period_q;
        end else if (run_q && tick) begin
          cnt_q <= (cnt_q == '0) ? period_q : cnt_q - COUNT_W'(1);
        end

        if (force_reload_p1) begin
          run_q <= 1'b0;
        end else if (wr_ctrl && writedata[3]) begin
          run_q <= 1'b0;
        end else if (wr_ctrl && writedata[2]) begin
          run_q <= 1'b1;
        end else if (timeout) begin
          run_q <= cont_q;
        end

        if (timeout) begin
          to_q <= 1'b1;
        end else if (wr_status) begin
          to_q <= 1'b0;
        end
      end
    end

    assign to_v[c]     = to_q;
    assign run_v[c]    = run_q;
    assign ito_v[c]    = ito_q;
    assign cont_v[c]   = cont_q;
    assign period_v[c] = period_wide;
    assign snap_v[c]   = 32'(snap_q);
  end

  always_comb begin
    rd_p0 = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (ch_sel == 8'(c)) begin
        case (offset)
          3'd0:    rd_p0 = {14'd0, run_v[c], to_v[c]};
          3'd1:    rd_p0 = {14'd0, cont_v[c], ito_v[c]};
          3'd2:    rd_p0 = period_v[c][15:0];
          3'd3:    rd_p0 = period_v[c][31:16];
          3'd4:    rd_p0 = snap_v[c][15:0];
          3'd5:    rd_p0 = snap_v[c][31:16];
          default: rd_p0 = '0;
        endcase
      end
    end
  end

  // Read data registered every clock from the current address.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= rd_p0;
    end
  end

  assign irq = |(to_v & ito_v);

endmodule

// File: tb/tb_sys_timer_multi.sv
// Directed bench for sys_timer_multi: a 2-channel PRESCALE=1 instance (a) and a 3-channel PRESCALE=4 instance (b).
module tb_sys_timer_multi;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [4:0]  bus_addr;
  logic        cs_a;
  logic        cs_b;
  logic        write_n;
  logic [15:0] wdata;
  logic [15:0] rd_a;
  logic [15:0] rd_b;
  logic        irq_a;
  logic        irq_b;

  int errors  = 0;
  int checks  = 0;
  int edge_no = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (reset_n) edge_no <= edge_no + 1;

  sys_timer_multi #(.CHANNELS(2), .COUNT_W(32), .RESET_PERIOD(32'h0000C34F), .PRESCALE(1)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .address(bus_addr[3:0]), .chipselect(cs_a),
    .write_n(write_n), .writedata(wdata), .readdata(rd_a), .irq(irq_a)
  );

  sys_timer_multi #(.CHANNELS(3), .COUNT_W(32), .RESET_PERIOD(32'h0000C34F), .PRESCALE(4)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .address(bus_addr), .chipselect(cs_b),
    .write_n(write_n), .writedata(wdata), .readdata(rd_b), .irq(irq_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wr(input bit b, input logic [4:0] a, input logic [15:0] d);
    @(negedge clk);
    bus_addr = a;
    wdata    = d;
    write_n  = 1'b0;
    cs_a     = !b;
    cs_b     = b;
    @(posedge clk);
    #1;
    write_n = 1'b1;
    cs_a    = 1'b0;
    cs_b    = 1'b0;
  endtask

  task automatic rd_chk(input bit b, input logic [4:0] a, input logic [15:0] exp, input string tag);
    logic [15:0] d;
    @(negedge clk);
    bus_addr = a;
    @(posedge clk);
    #1;
    d = b ? rd_b : rd_a;
    check(tag, {16'd0, d}, {16'd0, exp});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] snap_tbl [6];
    logic [31:0] exp32;
    int          irq_cnt;
    int          s_edge;
    int          m_edge;
    int          tick_cnt;

    snap_tbl = '{16'd3, 16'd1, 16'd4, 16'd2, 16'd0, 16'd3};
    reset_n  = 1'b0;
    bus_addr = '0;
    cs_a     = 1'b0;
    cs_b     = 1'b0;
    write_n  = 1'b1;
    wdata    = '0;
    repeat (2) @(negedge clk);
    check("rst_readdata", 32'(rd_a), 32'h0);
    check("rst_irq", 32'(irq_a), 32'h0);
    reset_n = 1'b1;

    // Reset values of channel 0
    rd_chk(0, 5'd0, 16'h0000, "rst_status");
    rd_chk(0, 5'd1, 16'h0000, "rst_ctrl");
    rd_chk(0, 5'd2, 16'hC34F, "rst_period_l");
    rd_chk(0, 5'd3, 16'h0000, "rst_period_h");
    rd_chk(0, 5'd4, 16'h0000, "rst_snap_l");
    check("rst_irq_after", 32'(irq_a), 32'h0);

    // Channel 1 continuous, period 4: timeout every 5 clocks
    wr(0, 5'd10, 16'd4);
    wr(0, 5'd11, 16'd0);
    idle(2);
    wr(0, 5'd9, 16'h0007);
    for (int n = 1; n <= 5; n++) begin
      idle(1);
      check($sformatf("c1_irq_a%0d", n), 32'(irq_a), 32'(n == 5));
    end
    wr(0, 5'd8, 16'h0000);
    check("c1_irq_cleared", 32'(irq_a), 32'h0);
    for (int n = 7; n <= 10; n++) begin
      idle(1);
      check($sformatf("c1_irq_b%0d", n), 32'(irq_a), 32'(n == 10));
    end
    wr(0, 5'd8, 16'h0000);
    for (int i = 0; i < 6; i++) begin
      logic [15:0] e;
      e = snap_tbl[i];
      wr(0, 5'd12, 16'h0000);
      rd_chk(0, 5'd12, e, $sformatf("c1_snap%0d", i));
    end
    wr(0, 5'd8, 16'h0000);
    wr(0, 5'd8, 16'h0000);
    rd_chk(0, 5'd8, 16'h0003, "c1_clear_vs_timeout");
    check("c1_irq_kept", 32'(irq_a), 32'h1);
    wr(0, 5'd9, 16'h0008);
    wr(0, 5'd8, 16'h0000);
    rd_chk(0, 5'd8, 16'h0000, "c1_stopped_status");
    rd_chk(0, 5'd9, 16'h0000, "c1_stopped_ctrl");
    rd_chk(0, 5'd10, 16'h0004, "c1_period_l");
    check("c1_irq_off", 32'(irq_a), 32'h0);

    // Channel 0 one-shot, period 2
    wr(0, 5'd2, 16'd2);
    wr(0, 5'd3, 16'd0);
    idle(2);
    wr(0, 5'd1, 16'h0005);
    for (int n = 1; n <= 3; n++) begin
      idle(1);
      check($sformatf("os_irq%0d", n), 32'(irq_a), 32'(n == 3));
    end
    rd_chk(0, 5'd0, 16'h0001, "os_status");
    wr(0, 5'd0, 16'h0000);
    irq_cnt = 0;
    for (int n = 0; n < 20; n++) begin
      idle(1);
      if (irq_a) irq_cnt++;
    end
    check("os_no_more_irq", 32'(irq_cnt), 32'h0);
    wr(0, 5'd4, 16'h0000);
    rd_chk(0, 5'd4, 16'h0002, "os_snap");

    // START, then START|STOP together; counter holds, START resumes
    wr(0, 5'd1, 16'h0004);
    rd_chk(0, 5'd0, 16'h0002, "ss_running");
    wr(0, 5'd1, 16'h000C);
    rd_chk(0, 5'd0, 16'h0000, "ss_stop_wins");
    wr(0, 5'd4, 16'h0000);
    rd_chk(0, 5'd4, 16'h0000, "ss_held_count");
    wr(0, 5'd1, 16'h0005);
    idle(1);
    check("ss_resume_irq", 32'(irq_a), 32'h1);
    rd_chk(0, 5'd0, 16'h0001, "ss_resume_status");
    wr(0, 5'd0, 16'h0000);

    // Period write while running: reload and stop two clocks after the strobe
    wr(0, 5'd1, 16'h0006);
    wr(0, 5'd2, 16'd7);
    wr(0, 5'd4, 16'h0000);
    rd_chk(0, 5'd4, 16'h0001, "pw_before_reload");
    wr(0, 5'd4, 16'h0000);
    rd_chk(0, 5'd4, 16'h0007, "pw_reloaded");
    rd_chk(0, 5'd0, 16'h0000, "pw_status");

    // Unmapped offsets on instance a
    rd_chk(0, 5'd6, 16'h0000, "um_off6");
    rd_chk(0, 5'd7, 16'h0000, "um_off7");
    rd_chk(0, 5'd14, 16'h0000, "um_off14");
    wr(0, 5'd6, 16'h0007);
    wr(0, 5'd7, 16'h0007);
    wr(0, 5'd15, 16'h0007);
    rd_chk(0, 5'd2, 16'h0007, "um_ch0_period");
    rd_chk(0, 5'd1, 16'h0002, "um_ch0_ctrl");
    rd_chk(0, 5'd0, 16'h0000, "um_ch0_status");
    rd_chk(0, 5'd9, 16'h0000, "um_ch1_ctrl");

    // Nonexistent channel 3 on instance b
    wr(1, 5'd25, 16'h0007);
    wr(1, 5'd26, 16'h1234);
    rd_chk(1, 5'd26, 16'h0000, "nc_period");
    rd_chk(1, 5'd25, 16'h0000, "nc_ctrl");
    rd_chk(1, 5'd2, 16'hC34F, "nc_ch0_period");
    rd_chk(1, 5'd18, 16'hC34F, "nc_ch2_period");
    rd_chk(1, 5'd17, 16'h0000, "nc_ch2_ctrl");
    check("nc_irq", 32'(irq_b), 32'h0);

    // 32-bit period 0x0001_0000 with PRESCALE=4 on instance b
    wr(1, 5'd2, 16'h0000);
    wr(1, 5'd3, 16'h0001);
    idle(2);
    wr(1, 5'd1, 16'h0005);
    s_edge = edge_no;
    wr(1, 5'd4, 16'h0000);
    rd_chk(1, 5'd5, 16'h0001, "p32_snap_h_start");
    rd_chk(1, 5'd4, 16'h0000, "p32_snap_l_start");
    rd_chk(1, 5'd3, 16'h0001, "p32_period_h");
    idle(40);
    wr(1, 5'd4, 16'h0000);
    m_edge   = edge_no;
    tick_cnt = 0;
    for (int k = s_edge + 1; k <= m_edge - 1; k++) begin
      if (k % 4 == 0) tick_cnt++;
    end
    exp32 = 32'h0001_0000 - 32'(tick_cnt);
    rd_chk(1, 5'd4, exp32[15:0], "p32_snap_l_mid");
    rd_chk(1, 5'd5, exp32[31:16], "p32_snap_h_mid");
    rd_chk(1, 5'd0, 16'h0002, "p32_status");
    check("p32_irq", 32'(irq_b), 32'h0);

    // Asynchronous reset mid-count
    wr(0, 5'd9, 16'h0007);
    idle(6);
    check("ar_irq_before", 32'(irq_a), 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    check("ar_irq_async", 32'(irq_a), 32'h0);
    check("ar_readdata_async", 32'(rd_a), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    rd_chk(0, 5'd8, 16'h0000, "ar_status");
    rd_chk(0, 5'd10, 16'hC34F, "ar_period_l");
    idle(8);
    check("ar_irq_idle", 32'(irq_a), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sys_timer_multi.md
# sys_timer_multi

Parametrised multi-channel interval timer on a 16-bit Avalon-MM slave: the next generation of the single fixed-period system timer. Each of CHANNELS independent down-counters has a software-writable period of up to 32 bits, one-shot or continuous mode, snapshot capture and a timeout flag. A shared prescaler paces all channels. The enabled timeout flags are OR-ed into one interrupt line to the CPU interrupt controller.

## Interface
- CHANNELS, default 2: number of timer channels, 1..8.
- COUNT_W, default 32: counter/period width, 16..32.
- RESET_PERIOD, default 32'h0000C34F: period and counter value at reset, truncated to COUNT_W.
- PRESCALE, default 1: tick divisor, ≥1; a tick occurs every PRESCALE clocks.
- ADDR_W, derived: 3 + clog2(CHANNELS), minimum 3.
- clk  in  1  system clock; everything is synchronous to its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  ADDR_W  word address; {channel, offset[2:0]}.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe; a write is chipselect && !write_n.
- writedata  in  16  write data.
- readdata  out  16  registered read data.
- irq  out  1  OR over channels of (TO && ITO).

## Operation
- Per-channel register map (offset within the channel):
  - 0 status: bit0 TO, bit1 RUN. Any write clears TO.
  - 1 control: bit0 ITO, bit1 CONT, bit2 START, bit3 STOP. Bits [1:0] are stored; START and STOP are write-only strobes that read back as 0.
  - 2 period_l: period[15:0].
  - 3 period_h: period[COUNT_W-1:16]. Unused bits read 0; with COUNT_W=16 writes are ignored and reads return 0.
  - 4 snap_l and 5 snap_h: a write to either captures the live counter into the snapshot register. Reads return snapshot[15:0] and snapshot[COUNT_W-1:16].
  - 6, 7 and nonexistent channels: read 0, writes ignored.
- Prescaler: free-running counter over 0..PRESCALE-1. tick is asserted when it equals PRESCALE-1; with PRESCALE=1, tick=1 on every clock.
- Per-channel counter, priority order per clock:
  1. force_reload (registered one clock after any period_l/period_h write): counter <= period, RUN <= 0.
  2. RUN && tick && counter==0: counter <= period, TO <= 1, RUN <= CONT.
  3. RUN && tick: counter <= counter-1.
- The interval is (period+1) ticks. period=0 gives a timeout on every tick.
- START sets RUN; STOP clears RUN; START and STOP together: STOP wins. The counter holds its value while stopped, and START resumes from that held value.
- A period write and a START in the same access cycle: force_reload on the next clock clears RUN.
- A status clear in the same clock as a timeout: the timeout wins and TO stays 1.
- A snapshot write captures the counter value from before that clock's update.
- Arithmetic is unsigned COUNT_W-bit. The decrement never underflows because zero always reloads.

## Timing
- Reset values: readdata 0, irq 0, TO/RUN/ITO/CONT 0, period and counter RESET_PERIOD, snapshot 0, prescaler 0.
- Read latency is 1 clock: readdata is registered every clock from the current address, regardless of chipselect.
- Writes take effect at the clock edge where the write strobe is sampled. Control, status and snapshot writes are visible to a read issued on the next clock.
- Period write to counter reload: 2 clocks (strobe → force_reload → counter loaded).
- TO rises on the clock edge where the zero-count tick is processed. irq is combinational from TO and ITO, so it asserts in that same cycle.
- A reset assertion mid-count asynchronously returns all state to its reset values. Counting resumes only after a new START.

## Test plan
- Reset, then read status/control/period of channel 0 → 0x0000, 0x0000, 0xC34F, 0x0000, and irq=0.
- Channel 1, PRESCALE=1: period_l=4, period_h=0, control=0x0007 (ITO|CONT|START) → TO and irq rise every 5 clocks; status write clears irq; counter sequence is 4,3,2,1,0,4.
- One-shot: period=2, control=0x0005 → exactly one timeout, then RUN=0 with counter=2; no further irq over 20 clocks.
- 32-bit period=0x0001_0000 with PRESCALE=4 → first TO after 65537×4 clocks. A snap_l write mid-run, then snap_h/snap_l reads, returns a value consistent with elapsed ticks.
- Collisions:
  - START|STOP written together → RUN=0.
  - Status clear coincident with a timeout → TO=1.
  - Period write while running → RUN=0 and counter=new period two clocks later.
- Unmapped offsets 6/7 and channel index ≥ CHANNELS read 0; writes there leave all channels unchanged.
